// File: rtl/aes_ghash_accumulator_if.sv
// aes_ghash_accumulator_if: block handshake and result bundle between a GHASH source and the accumulator
interface aes_ghash_accumulator_if;
  logic i_start;
  logic [127:0] i_h;
  logic i_valid;
  logic o_ready;
  logic [127:0] i_block;
  logic i_last;
  logic [127:0] o_sblock;
  logic [127:0] o_h;
  logic o_sblock_valid;
  logic o_busy;
  modport master(output i_start, i_h, i_valid, i_block, i_last, input o_ready, o_sblock, o_h, o_sblock_valid, o_busy);
  modport slave(input i_start, i_h, i_valid, i_block, i_last, output o_ready, o_sblock, o_h, o_sblock_valid, o_busy);
endinterface

// File: rtl/aes_ghash_accumulator.sv
// aes_ghash_accumulator: iterative GHASH S = (S ^ X) * H over GF(2^128), DIGITS multiplier bits per cycle
module aes_ghash_accumulator #(
  parameter int DIGITS = 8
) (
  input logic clk,
  input logic rst_n,
  aes_ghash_accumulator_if.slave bus
);
  localparam int STEPS = 128 / DIGITS;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  // bit k is the coefficient of x^k, so x^128 folds back to 1 + x + x^2 + x^7
  localparam logic [127:0] R = 128'h87;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [127:0] s, h, x, z, v, z_nx, v_nx;
  logic [CW-1:0] cnt;
  logic last_q, sv, idle, busy, fin;
  assign idle = state == IDLE;
  assign busy = state == MUL;
  assign fin = busy && !bus.i_start && cnt == LAST;
  always_comb begin
    state_nx = idle ? (bus.i_valid ? MUL : IDLE) : (bus.i_start || fin ? IDLE : MUL);
  end
  // x is shifted down each cycle so the current digit always sits in its low bits
  always_comb begin
    z_nx = z;
    v_nx = v;
    for (int i = 0; i < DIGITS; i++) begin
      z_nx = x[i] ? z_nx ^ v_nx : z_nx;
      v_nx = v_nx[127] ? {v_nx[126:0], 1'b0} ^ R : {v_nx[126:0], 1'b0};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s <= '0;
      h <= '0;
      x <= '0;
      z <= '0;
      v <= '0;
      cnt <= '0;
      last_q <= 1'b0;
      sv <= 1'b0;
    end else begin
      state <= state_nx;
      sv <= fin && last_q;
      if (bus.i_start) begin
        s <= '0;
        h <= bus.i_h;
      end
      if (idle && bus.i_valid) begin
        x <= (bus.i_start ? '0 : s) ^ bus.i_block;
        z <= '0;
        v <= bus.i_start ? bus.i_h : h;
        cnt <= '0;
        last_q <= bus.i_last;
      end else if (busy && !bus.i_start) begin
        x <= x >> DIGITS;
        z <= z_nx;
        v <= v_nx;
        cnt <= cnt + 1'b1;
        if (fin) s <= z_nx;
      end
    end
  assign bus.o_ready = idle;
  assign bus.o_busy = busy;
  assign bus.o_sblock = s;
  assign bus.o_h = h;
  assign bus.o_sblock_valid = sv;
endmodule
